// File: rtl/rf_pkg.sv
// Shared defaults, address-width helper and common types for the register file slice.
package rf_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;

    // Address width for a given register count; never narrower than one bit.
    function automatic int unsigned rf_aw(input int unsigned nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

    localparam int unsigned AW_DEF = rf_aw(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   regaddr_t;
    typedef logic [XLEN_DEF-1:0] word_t;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding producer and stalls WAW issues.
module reg_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NWR   = 1,
    parameter int unsigned AW    = rf_aw(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NWR-1:0]    wr_act_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    input  logic              iss_valid_i,
    input  logic [AW-1:0]     iss_rd_i,
    output logic              iss_ready_o,
    output logic [NREGS-1:0]  busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] clr;
    logic [NREGS-1:0] set;
    logic             ready;

    always_comb begin
        clr = '0;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wr_act_i[j]) begin
                clr[wr_addr_i[j*AW +: AW]] = 1'b1;
            end
        end
    end

    // A write retiring the current producer frees the slot in the same cycle.
    assign ready = (iss_rd_i == '0) || !busy_q[iss_rd_i] || clr[iss_rd_i];

    always_comb begin
        set = '0;
        if (iss_valid_i && ready && (iss_rd_i != '0)) begin
            set[iss_rd_i] = 1'b1;
        end
        // Set after clear: a new producer outranks the retiring one.
        busy_d    = (busy_q & ~clr) | set;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign iss_ready_o = ready;
    assign busy_o      = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-ported register file with x0 hardwired to zero, optional write bypass and a WAW scoreboard.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 1,
    parameter int unsigned BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NRD*rf_aw(NREGS)-1:0] rd_addr,
    output logic [NRD*XLEN-1:0]      rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR*rf_aw(NREGS)-1:0] wr_addr,
    input  logic [NWR*XLEN-1:0]      wr_data,
    input  logic                     iss_valid,
    input  logic [rf_aw(NREGS)-1:0]  iss_rd,
    output logic                     iss_ready
);

    localparam int unsigned AW = rf_aw(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NWR-1:0]   wr_act;
    logic [NREGS-1:0] busy;

    // Gating with rst_n keeps bypass data and scoreboard clears invisible during reset.
    always_comb begin
        wr_act = '0;
        for (int unsigned j = 0; j < NWR; j++) begin
            wr_act[j] = rst_n && wr_en[j] && (wr_addr[j*AW +: AW] != '0);
        end
    end

    // Ascending port order lets the highest-numbered port win on address collisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < NWR; j++) begin
                if (wr_act[j]) begin
                    regs_q[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        logic [AW-1:0]   a;
        logic            hit;
        logic [XLEN-1:0] fwd;
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            a   = rd_addr[i*AW +: AW];
            hit = 1'b0;
            fwd = '0;
            for (int unsigned j = 0; j < NWR; j++) begin
                if (wr_act[j] && (wr_addr[j*AW +: AW] == a)) begin
                    hit = 1'b1;
                    fwd = wr_data[j*XLEN +: XLEN];
                end
            end
            if ((BYPASS != 0) && hit) begin
                rd_data[i*XLEN +: XLEN] = fwd;
                rd_busy[i]              = 1'b0;
            end else begin
                rd_data[i*XLEN +: XLEN] = regs_q[a];
                rd_busy[i]              = busy[a];
            end
        end
    end

    reg_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wr_act_i    (wr_act),
        .wr_addr_i   (wr_addr),
        .iss_valid_i (iss_valid),
        .iss_rd_i    (iss_rd),
        .iss_ready_o (iss_ready),
        .busy_o      (busy)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized and directed checks of two register file configurations against an array-based model.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;

    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic        iss_ready_a, iss_ready_b;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic        chk_en = 1'b0;

    // Model state: instance 0 = NWR 1 with bypass, instance 1 = NWR 2 without bypass.
    logic [31:0] mr [2][32];
    logic        mb [2][32];

    always #5 clk = ~clk;

    reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[4:0]), .wr_data(wr_data[31:0]),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready_a)
    );

    reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready_b)
    );

    task automatic chk(input string nm, input int k, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d port%0d @%0t: got %h expected %h", nm, k, i, $time, act, exp);
        end
    endtask

    function automatic logic wact(input int k, input int j);
        return rst_n && (j < ((k == 0) ? 1 : 2)) && wr_en[j] && (wr_addr[j*5 +: 5] != 5'd0);
    endfunction

    // Returns 1 and the last matching write's data when a same-cycle write targets a.
    function automatic logic whit(input int k, input logic [4:0] a, output logic [31:0] d);
        logic h = 1'b0;
        d = '0;
        for (int j = 0; j < 2; j++) begin
            if (wact(k, j) && wr_addr[j*5 +: 5] == a) begin
                h = 1'b1;
                d = wr_data[j*32 +: 32];
            end
        end
        return h;
    endfunction

    function automatic logic [31:0] exp_rd(input int k, input int i);
        logic [4:0]  a = rd_addr[i*5 +: 5];
        logic [31:0] d;
        if (!rst_n || a == 5'd0) return 32'h0;
        if (k == 0 && whit(k, a, d)) return d;
        return mr[k][a];
    endfunction

    function automatic logic exp_rbusy(input int k, input int i);
        logic [4:0]  a = rd_addr[i*5 +: 5];
        logic [31:0] d;
        if (!rst_n || a == 5'd0) return 1'b0;
        if (k == 0 && whit(k, a, d)) return 1'b0;
        return mb[k][a];
    endfunction

    function automatic logic exp_ready(input int k);
        logic [31:0] d;
        if (iss_rd == 5'd0 || !mb[k][iss_rd]) return 1'b1;
        return whit(k, iss_rd, d);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++)
                for (int r = 0; r < 32; r++) begin
                    mr[k][r] = 32'h0;
                    mb[k][r] = 1'b0;
                end
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic rdy;
                rdy = exp_ready(k);
                for (int j = 0; j < 2; j++) begin
                    if (wact(k, j)) begin
                        mr[k][wr_addr[j*5 +: 5]] = wr_data[j*32 +: 32];
                        mb[k][wr_addr[j*5 +: 5]] = 1'b0;
                    end
                end
                if (iss_valid && rdy && iss_rd != 5'd0) mb[k][iss_rd] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("rd_data", 0, i, rd_data_a[i*32 +: 32], exp_rd(0, i));
                chk("rd_data", 1, i, rd_data_b[i*32 +: 32], exp_rd(1, i));
                chk("rd_busy", 0, i, {31'b0, rd_busy_a[i]}, {31'b0, exp_rbusy(0, i)});
                chk("rd_busy", 1, i, {31'b0, rd_busy_b[i]}, {31'b0, exp_rbusy(1, i)});
            end
            chk("iss_ready", 0, 0, {31'b0, iss_ready_a}, {31'b0, exp_ready(0)});
            chk("iss_ready", 1, 0, {31'b0, iss_ready_b}, {31'b0, exp_ready(1)});
        end
    end

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_valid = 1'b0; iss_rd = '0; rd_addr = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [4:0] raddr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        step();
        chk_en = 1'b1;

        // Activity while in reset must stay invisible.
        wr_en = 2'b11; wr_addr = {5'd4, 5'd4}; wr_data = {32'hAAAA5555, 32'h12345678};
        rd_addr = {5'd4, 5'd4}; iss_valid = 1'b1; iss_rd = 5'd4;
        mid();
        chk("rst_data", 0, 0, rd_data_a[31:0], 32'h0);
        chk("rst_data", 1, 1, rd_data_b[63:32], 32'h0);
        chk("rst_busy", 0, 0, {31'b0, rd_busy_a[0]}, 32'h0);
        chk("rst_ready", 0, 0, {31'b0, iss_ready_a}, 32'h1);
        chk("rst_ready", 1, 0, {31'b0, iss_ready_b}, 32'h1);
        step();
        rst_n = 1'b1;
        idle();

        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(a), 5'(a)};
            mid();
            chk("init_data", 0, 0, rd_data_a[31:0], 32'h0);
            chk("init_data", 0, 1, rd_data_a[63:32], 32'h0);
            chk("init_data", 1, 1, rd_data_b[63:32], 32'h0);
            chk("init_busy", 0, 1, {31'b0, rd_busy_a[1]}, 32'h0);
            step();
        end

        for (int c = 0; c < 400; c++) begin
            rd_addr   = {raddr(), raddr()};
            wr_en     = 2'($urandom_range(0, 3));
            wr_addr   = {raddr(), raddr()};
            wr_data   = {$urandom, $urandom};
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd    = raddr();
            if (c == 200) rst_n = 1'b0;
            if (c == 204) rst_n = 1'b1;
            step();
        end

        rst_n = 1'b0;
        idle();
        step();
        step();

        // Write presented in the deassert cycle, with a same-cycle read.
        rst_n = 1'b1;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF}; rd_addr = {5'd0, 5'd5};
        mid();
        chk("x5_bypass", 0, 0, rd_data_a[31:0], 32'hDEADBEEF);
        chk("x5_nobypass", 1, 0, rd_data_b[31:0], 32'h0);
        step();
        idle(); rd_addr = {5'd5, 5'd5};
        mid();
        chk("x5_read", 0, 0, rd_data_a[31:0], 32'hDEADBEEF);
        chk("x5_read", 0, 1, rd_data_a[63:32], 32'hDEADBEEF);
        chk("x5_read", 1, 0, rd_data_b[31:0], 32'hDEADBEEF);
        chk("x5_read", 1, 1, rd_data_b[63:32], 32'hDEADBEEF);
        step();

        idle(); wr_en = 2'b01; wr_data = {32'h0, 32'h1234}; iss_valid = 1'b1; iss_rd = 5'd0;
        mid();
        chk("x0_data", 0, 0, rd_data_a[31:0], 32'h0);
        chk("x0_ready", 0, 0, {31'b0, iss_ready_a}, 32'h1);
        step();
        wr_en = 2'b00;
        mid();
        chk("x0_data2", 1, 0, rd_data_b[31:0], 32'h0);
        chk("x0_busy", 0, 0, {31'b0, rd_busy_a[0]}, 32'h0);
        chk("x0_ready2", 0, 0, {31'b0, iss_ready_a}, 32'h1);
        step();

        idle(); iss_valid = 1'b1; iss_rd = 5'd7; rd_addr = {5'd7, 5'd7};
        mid();
        chk("x7_first", 0, 0, {31'b0, iss_ready_a}, 32'h1);
        step();
        mid();
        chk("x7_waw", 0, 0, {31'b0, iss_ready_a}, 32'h0);
        chk("x7_waw", 1, 0, {31'b0, iss_ready_b}, 32'h0);
        chk("x7_busy", 0, 0, {31'b0, rd_busy_a[0]}, 32'h1);
        step();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'h55};
        mid();
        chk("x7_clr_ready", 0, 0, {31'b0, iss_ready_a}, 32'h1);
        chk("x7_fwd", 0, 0, rd_data_a[31:0], 32'h55);
        chk("x7_fwd_busy", 0, 0, {31'b0, rd_busy_a[0]}, 32'h0);
        chk("x7_old", 1, 0, rd_data_b[31:0], 32'h0);
        chk("x7_old_busy", 1, 0, {31'b0, rd_busy_b[0]}, 32'h1);
        step();
        idle(); rd_addr = {5'd7, 5'd7};
        mid();
        chk("x7_after", 0, 0, rd_data_a[31:0], 32'h55);
        chk("x7_after", 1, 1, rd_data_b[63:32], 32'h55);
        chk("x7_still_busy", 0, 0, {31'b0, rd_busy_a[0]}, 32'h1);
        chk("x7_still_busy", 1, 1, {31'b0, rd_busy_b[1]}, 32'h1);
        step();

        idle(); wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'h22, 32'h11}; rd_addr = {5'd3, 5'd3};
        mid();
        chk("x3_same", 1, 0, rd_data_b[31:0], 32'h0);
        chk("x3_same", 0, 0, rd_data_a[31:0], 32'h11);
        step();
        idle(); rd_addr = {5'd3, 5'd3};
        mid();
        chk("x3_win", 1, 0, rd_data_b[31:0], 32'h22);
        chk("x3_win", 1, 1, rd_data_b[63:32], 32'h22);
        chk("x3_single", 0, 0, rd_data_a[31:0], 32'h11);
        step();

        idle(); wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h99};
        step();
        idle(); iss_valid = 1'b1; iss_rd = 5'd9;
        mid();
        chk("x9_issue", 0, 0, {31'b0, iss_ready_a}, 32'h1);
        step();
        idle(); rd_addr = {5'd9, 5'd9};
        mid();
        chk("x9_pre", 0, 0, rd_data_a[31:0], 32'h99);
        chk("x9_pre_busy", 0, 0, {31'b0, rd_busy_a[0]}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("x9_async", 0, 0, rd_data_a[31:0], 32'h0);
        chk("x9_async_busy", 0, 0, {31'b0, rd_busy_a[0]}, 32'h0);
        chk("x9_async", 1, 1, rd_data_b[63:32], 32'h0);
        chk("x9_async_busy", 1, 1, {31'b0, rd_busy_b[1]}, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
